// File: rtl/pcm_serializer.sv
// pcm_serializer: transmit-side PCM serializer.
// Takes WIDTH-bit samples through a valid/ready handshake into a one-word
// holding register. Each sample goes out MSB first on d_out, one bit per bclk,
// in SLOT_BITS-bit slots. ws is high for the first half of every slot.
// Optional feature macro: PCM_SERIALIZER_REPEAT_LAST_EN. When it is defined,
// an underrun slot repeats the last transmitted sample instead of zeros.
module pcm_serializer #(
  parameter int WIDTH     = 18,
  parameter int SLOT_BITS = 32
) (
  input  logic             bclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             ws,
  output logic             busy,
  output logic             underrun
);

  localparam int            CW       = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] HALF     = CW'(SLOT_BITS / 2);

  // A slot must fit the sample plus at least one trailing zero, and must
  // split evenly for ws.
  if (WIDTH < 2 || SLOT_BITS < WIDTH + 1 || (SLOT_BITS % 2) != 0) begin : g_bad_cfg
    $error("pcm_serializer: need WIDTH>=2, SLOT_BITS>=WIDTH+1, SLOT_BITS even");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;      // bits of the current slot still to be sent
  logic [WIDTH-1:0] fill_word;  // word a slot start loads
  logic             slot_end;
  logic             consume;
  logic             accept;

  assign slot_end   = (state == RUN) && (bit_cnt == LAST_BIT);
  // A slot start always empties the holding register, so it can take a
  // new word on that same edge.
  assign consume    = enable && ((state == IDLE) || slot_end);
  assign load_ready = ~hold_full | consume;
  assign accept     = load_valid & load_ready;
  assign cnt_nxt    = bit_cnt + 1'b1;

`ifdef PCM_SERIALIZER_REPEAT_LAST_EN
  logic [WIDTH-1:0] last_word;

  assign fill_word = hold_full ? hold : last_word;

  // Remember what each slot carried so an underrun can repeat it.
  always_ff @(posedge bclk or negedge reset) begin
    if (!reset)       last_word <= '0;
    else if (consume) last_word <= fill_word;
  end
`else
  assign fill_word = hold_full ? hold : '0;
`endif

  // Holding register. On a slot start that also accepts a word, the new
  // word replaces the one being consumed.
  always_ff @(posedge bclk or negedge reset) begin
    if (!reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= data;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  // Slot FSM: starts slots, shifts bits out, and drives the registered
  // outputs.
  always_ff @(posedge bclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      d_out    <= 1'b0;
      ws       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (consume) begin
        // The MSB goes straight to d_out. shreg keeps the rest, left-aligned.
        state    <= RUN;
        bit_cnt  <= '0;
        shreg    <= {fill_word[WIDTH-2:0], 1'b0};
        d_out    <= fill_word[WIDTH-1];
        ws       <= 1'b1;
        busy     <= 1'b1;
        underrun <= ~hold_full;
      end else if (slot_end) begin
        // enable is low at the end of the slot, so stop and leave hold untouched.
        state   <= IDLE;
        bit_cnt <= '0;
        d_out   <= 1'b0;
        ws      <= 1'b0;
        busy    <= 1'b0;
      end else if (state == RUN) begin
        // Shifting in zeros makes the slot tail after the sample all zero.
        bit_cnt <= cnt_nxt;
        d_out   <= shreg[WIDTH-1];
        shreg   <= {shreg[WIDTH-2:0], 1'b0};
        ws      <= (cnt_nxt < HALF);
      end
    end
  end

endmodule

// File: tb/tb_pcm_serializer.sv
// Scoreboard bench for pcm_serializer. The stimulus thread pushes the expected
// per-bit {d_out, ws, underrun} triples of each planned slot. A monitor pops
// and compares them on every falling edge while busy is high.
module tb_pcm_serializer;
  localparam int W = 18;
  localparam int S = 32;

  logic         bclk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] data;
  logic         load_valid;
  logic         load_ready, d_out, ws, busy, underrun;

  typedef struct packed {logic d; logic ws; logic ur;} exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   slot_bit_idx = 0;

  pcm_serializer #(.WIDTH(W), .SLOT_BITS(S)) dut (
    .bclk(bclk), .reset(reset), .enable(enable), .data(data),
    .load_valid(load_valid), .load_ready(load_ready), .d_out(d_out),
    .ws(ws), .busy(busy), .underrun(underrun)
  );

  always #5 bclk = ~bclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the 32 expected bit triples of one slot carrying w.
  task automatic push_slot(input logic [W-1:0] w, input logic ur);
    exp_t e;
    for (int k = 0; k < S; k++) begin
      e.d  = (k < W) ? w[W-1-k] : 1'b0;
      e.ws = (k < S/2);
      e.ur = (k == 0) ? ur : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge bclk);
    #2;
  endtask

  // Monitor: compare each busy cycle against the scoreboard. Outside a slot,
  // all registered outputs must be quiet.
  always @(negedge bclk) begin
    exp_t e;
    if (busy === 1'b1) begin
      if (q.size() == 0) begin
        chk("busy with no slot expected", 32'(busy), 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("slot bit %0d {d,ws,ur}", slot_bit_idx % S),
            32'({d_out, ws, underrun}), 32'(e));
        slot_bit_idx++;
      end
    end else begin
      chk("idle outputs {d,ws,ur}", 32'({d_out, ws, underrun}), 32'd0);
    end
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    logic [W-1:0] rep;
    reset = 1'b1; enable = 1'b0; data = '0; load_valid = 1'b0;
    #1 reset = 1'b0;

    // Reset and idle
    step(3);
    chk("reset d_out", 32'(d_out), 32'd0);
    chk("reset ws", 32'(ws), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset underrun", 32'(underrun), 32'd0);
    chk("reset load_ready", 32'(load_ready), 32'd1);
    reset = 1'b1;
    step(2);
    chk("post-reset busy", 32'(busy), 32'd0);
    chk("post-reset d_out", 32'(d_out), 32'd0);

    // Single sample, preloaded in IDLE
    data = 18'h2A5A5; load_valid = 1'b1;
    #1 chk("preload ready", 32'(load_ready), 32'd1);
    step(1);
    load_valid = 1'b0;
    #1 chk("hold full in idle", 32'(load_ready), 32'd0);
    push_slot(18'h2A5A5, 1'b0);
    enable = 1'b1;
    #1 chk("ready at slot-start edge", 32'(load_ready), 32'd1);
    step(1);
    chk("ready after consume", 32'(load_ready), 32'd1);
    step(5); enable = 1'b0;
    step(27);
    chk("single done busy", 32'(busy), 32'd0);
    chk("single queue drained", 32'(q.size()), 32'd0);

    // Back-to-back
    data = 18'h3FFFF; load_valid = 1'b1;
    step(1);
    data = 18'h00001;
    push_slot(18'h3FFFF, 1'b0);
    push_slot(18'h00001, 1'b0);
    enable = 1'b1;
    step(1);
    #1 chk("b2b ready while full", 32'(load_ready), 32'd0);
    load_valid = 1'b0;
    step(15);
    chk("b2b ready mid-slot", 32'(load_ready), 32'd0);
    step(16);
    chk("b2b ready at slot end", 32'(load_ready), 32'd1);
    step(1);
    chk("b2b second slot busy", 32'(busy), 32'd1);
    step(5); enable = 1'b0;
    step(27);
    chk("b2b done busy", 32'(busy), 32'd0);
    chk("b2b queue drained", 32'(q.size()), 32'd0);

    // Stop mid-slot with a word pending, then resume and underrun twice
    data = 18'h12345; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    push_slot(18'h12345, 1'b0);
    enable = 1'b1;
    step(1);
    data = 18'h2A5A5; load_valid = 1'b1;
    #1 chk("stop ready empty", 32'(load_ready), 32'd1);
    step(1);
    load_valid = 1'b0;
    #1 chk("stop ready full", 32'(load_ready), 32'd0);
    step(4); enable = 1'b0;
    step(27);
    chk("stop idle busy", 32'(busy), 32'd0);
    chk("stop hold kept", 32'(load_ready), 32'd0);
    step(3);
    chk("stop still idle", 32'(busy), 32'd0);
    chk("stop hold still kept", 32'(load_ready), 32'd0);
`ifdef PCM_SERIALIZER_REPEAT_LAST_EN
    rep = 18'h2A5A5;
`else
    rep = '0;
`endif
    push_slot(18'h2A5A5, 1'b0);
    push_slot(rep, 1'b1);
    push_slot(rep, 1'b1);
    enable = 1'b1;
    step(1);
    step(32);
    chk("underrun pulse 1", 32'(underrun), 32'd1);
    step(1);
    chk("underrun one cycle", 32'(underrun), 32'd0);
    step(31);
    chk("underrun pulse 2", 32'(underrun), 32'd1);
    step(5); enable = 1'b0;
    step(27);
    chk("underrun done busy", 32'(busy), 32'd0);
    chk("underrun queue drained", 32'(q.size()), 32'd0);

    // Reset mid-slot with a pending word that must be discarded
    data = 18'h15555; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    push_slot(18'h15555, 1'b0);
    enable = 1'b1;
    step(1);
    data = 18'h2AAAA; load_valid = 1'b1;
    step(1);
    load_valid = 1'b0;
    step(9);
    reset = 1'b0; enable = 1'b0;
    #1;
    chk("async reset d_out", 32'(d_out), 32'd0);
    chk("async reset ws", 32'(ws), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("bits sent before reset", 32'(q.size()), 32'(S - 10));
    q.delete();
    step(2);
    chk("reset discards hold", 32'(load_ready), 32'd1);
    reset = 1'b1; enable = 1'b1;
    push_slot('0, 1'b1);
    step(1);
    chk("first slot underrun", 32'(underrun), 32'd1);
    step(5); enable = 1'b0;
    step(27);
    chk("final busy", 32'(busy), 32'd0);
    chk("final queue drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
